ex_mem_pipe_stage: RTL and testbench
====================================

Name: ex_mem_pipe_stage

Overview:
- Parametrised, elastic EX/MEM pipeline stage that replaces the fixed, always-advancing EX/MEM register.
- Carries branch target, ALU result, store data, zero flag, destination register and MEM/WB control bits from EX to MEM.
- Adds valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble squashing, so EX can run under MEM back-pressure without losing or duplicating instructions.

Parameters:
- DATA_W, 32, width of pc_tgt, result and store data fields.
- REG_W, 5, width of destination register index.
- CTRL_W, 5, width of control bundle; bit0 branch, bit1 memRead, bit2 memWrite, bit3 regwrite, bit4 MemtoReg; any extra bits are passed through.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  EX presents a valid instruction.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- pc_tgt_in  input  DATA_W  branch target.
- result_in  input  DATA_W  ALU result.
- b_in  input  DATA_W  store data.
- zero_in  input  1  ALU zero flag.
- rd_in  input  REG_W  destination register.
- ctrl_in  input  CTRL_W  control bundle.
- out_valid  output  1  MEM-side entry valid.
- out_ready  input  1  MEM consumes the entry this cycle.
- pc_tgt_out, result_out, b_out  output  DATA_W  registered payload.
- zero_out  output  1  registered zero flag.
- rd_out  output  REG_W  registered destination.
- ctrl_out  output  CTRL_W  registered control; all zero whenever out_valid=0.
- occupancy  output  2  entries held: 0, 1 or 2.
- perf_clr  input  1  synchronous clear of counters (optional feature).
- stall_cnt, bubble_cnt  output  CNT_W  performance counters (optional feature).

Behaviour:
- Reset: out_valid=0, skid_valid=0, occupancy=0, all payload and ctrl registers 0, counters 0. in_ready=1 during and after reset.
- Reset asserted mid-transfer discards both entries; no partial state survives.
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: one cycle from accept to out_valid when the stage is empty; full throughput (1 per cycle) while out_ready=1.
- Transitions on each edge when flush=0:
  - EMPTY (occ 0): on accept, the input loads the output register; next state ONE.
  - ONE: accept & drain → the input replaces the output register; stay ONE.
  - ONE: accept & !drain → the input loads the skid register; next state FULL, in_ready=0.
  - ONE: !accept & drain → next state EMPTY.
  - FULL: in_ready=0, so no accept is possible. On drain, the skid entry moves to the output register and skid clears; next state ONE.
  - FULL: hold otherwise.
- Ordering is strict FIFO. The skid entry never bypasses the output entry.
- Flush: next state EMPTY. out_valid=0, skid_valid=0, and stored ctrl cleared to 0. An input presented in the same cycle is dropped, even if in_valid=1. flush overrides simultaneous drain/accept.
- Bubble squash: when out_valid=0, ctrl_out is forced to 0. Data outputs keep their last value (don't-care).
- out_ready while out_valid=0 is ignored.
- in_ready is registered-state-derived only; it has no combinational path from out_ready.

Optional Feature:
- Macro EX_MEM_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with out_valid=0 (excluding reset).
  - Both saturate at all-ones.
  - perf_clr zeroes both next edge; clear has priority over increment.
- Undefined: counters are not instantiated; stall_cnt and bubble_cnt are tied to 0 and perf_clr is ignored. All other behaviour is identical.

Test Plan:
- Reset release, then in_valid=1, result_in=0x0000_00AA, ctrl_in=5'b01000, out_ready=1 → next cycle out_valid=1, result_out=0xAA, ctrl_out=5'b01000, occupancy=1.
- Stream 4 back-to-back entries (results 1..4) with out_ready=1 → outputs 1,2,3,4 on consecutive cycles; in_ready stays 1.
- Hold out_ready=0 and send entries 0x10, 0x11 → occupancy=2, in_ready=0. Entry 0x12 is held off. Raise out_ready → 0x10, 0x11, 0x12 appear in order with no loss or duplicate.
- With occupancy=2, assert flush together with in_valid=1 → next cycle out_valid=0, ctrl_out=0, occupancy=0, in_ready=1. The flushed-cycle input never appears.
- Assert reset asynchronously mid-cycle while FULL → out_valid drops immediately, occupancy=0, ctrl_out=0 without waiting for a clock edge.
- With EX_MEM_PERF_EN defined: 3 cycles of out_valid=1 & out_ready=0, then 2 empty cycles → stall_cnt=3, bubble_cnt=2. perf_clr → both 0.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage
//   Elastic EX/MEM pipeline stage. It carries the branch target, ALU result,
//   store data, zero flag, destination register and MEM/WB control bits from
//   EX to MEM behind a valid/ready handshake. A 2-entry skid buffer (output
//   register + skid register) lets EX keep issuing under MEM back-pressure
//   without losing or duplicating instructions.
//
//   Optional feature: define EX_MEM_PERF_EN to build the stall/bubble
//   performance counters. Without it, stall_cnt/bubble_cnt read 0 and
//   perf_clr is ignored.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   flush               synchronous squash of every held entry and the input
//   in_valid/in_ready   EX-side handshake (in_ready = no skid entry held)
//   pc_tgt_in..ctrl_in  EX payload
//   out_valid/out_ready MEM-side handshake
//   pc_tgt_out..ctrl_out registered payload; ctrl_out is 0 when out_valid=0
//   occupancy           entries held (0, 1 or 2)
//   perf_clr            clear both performance counters
//   stall_cnt           cycles with out_valid & !out_ready (saturating)
//   bubble_cnt          cycles with out_valid = 0 (saturating)

module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_tgt_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              zero_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc_tgt_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] b_out,
  output logic              zero_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [1:0]        occupancy,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Payload is packed into one vector; ctrl sits in the low bits so the
  // flush path can clear just that slice.
  localparam int PAY_W = 3 * DATA_W + 1 + REG_W + CTRL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay_reg;
  logic [PAY_W-1:0] skid_pay_reg;

  logic accept, drain;
  logic load_out_in, load_out_skid, load_skid, clr_ctrl;
  logic skid_valid;

  assign in_pay = {pc_tgt_in, result_in, b_in, zero_in, rd_in, ctrl_in};

  // Handshake flags depend on registered state only, so in_ready has no
  // combinational path from out_ready.
  assign out_valid  = (state_reg != EMPTY);
  assign skid_valid = (state_reg == FULL);
  assign in_ready   = ~skid_valid;
  assign occupancy  = state_reg;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush wins over any simultaneous accept/drain
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) state_next = ONE;
        ONE: begin
          if (accept && !drain) begin
            state_next = FULL;
          end else if (!accept && drain) begin
            state_next = EMPTY;
          end
        end
        FULL:    if (drain) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Datapath strobes
  always_comb begin
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    clr_ctrl      = 1'b0;
    if (flush) begin
      clr_ctrl = 1'b1;
    end else begin
      case (state_reg)
        EMPTY: load_out_in = accept;
        ONE: begin
          load_out_in = accept & drain;
          load_skid   = accept & ~drain;
        end
        FULL:    load_out_skid = drain;
        default: ;
      endcase
    end
  end

  // Payload registers. The skid entry only ever moves into the output
  // register, never past it, which keeps the stage strictly FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pay_reg  <= '0;
      skid_pay_reg <= '0;
    end else if (clr_ctrl) begin
      out_pay_reg[CTRL_W-1:0]  <= '0;
      skid_pay_reg[CTRL_W-1:0] <= '0;
    end else begin
      if (load_out_in) begin
        out_pay_reg <= in_pay;
      end else if (load_out_skid) begin
        out_pay_reg <= skid_pay_reg;
      end
      if (load_skid) begin
        skid_pay_reg <= in_pay;
      end
    end
  end

  assign {pc_tgt_out, result_out, b_out, zero_out, rd_out} = out_pay_reg[PAY_W-1:CTRL_W];

  // Bubble squash: downstream never sees control bits without a valid entry
  assign ctrl_out = out_valid ? out_pay_reg[CTRL_W-1:0] : '0;

`ifdef EX_MEM_PERF_EN
  // Bit 0 -> stall counter, bit 1 -> bubble counter
  logic [1:0] perf_inc;
  assign perf_inc = {~out_valid, out_valid & ~out_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (perf_clr) begin
          cnt_reg <= '0;
        end else if (perf_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt  = g_perf[0].cnt_reg;
  assign bubble_cnt = g_perf[1].cnt_reg;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt       = '0;
  assign bubble_cnt      = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage with a queue scoreboard: every accepted
// input pushes its expected payload, every drain pops and compares.
module tb_ex_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_tgt_in, result_in, b_in;
  logic        zero_in;
  logic [4:0]  rd_in;
  logic [4:0]  ctrl_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_tgt_out, result_out, b_out;
  logic        zero_out;
  logic [4:0]  rd_out;
  logic [4:0]  ctrl_out;
  logic [1:0]  occupancy;
  logic        perf_clr;
  logic [15:0] stall_cnt, bubble_cnt;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  ctl;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   npop       = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_tgt_in(pc_tgt_in), .result_in(result_in), .b_in(b_in),
    .zero_in(zero_in), .rd_in(rd_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_tgt_out(pc_tgt_out), .result_out(result_out), .b_out(b_out),
    .zero_out(zero_out), .rd_out(rd_out), .ctrl_out(ctrl_out),
    .occupancy(occupancy), .perf_clr(perf_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs set; records the transfers that the
  // next rising edge will perform, then waits for the following negedge.
  task automatic tick();
    exp_t e;
    if (flush) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        e.res = result_in;
        e.ctl = ctrl_in;
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", result_out, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          npop++;
          $display("drain result=%0h ctrl=%0h", result_out, ctrl_out);
          chk("result", result_out, e.res);
          chk("ctrl", 32'(ctrl_out), 32'(e.ctl));
          chk("rd", 32'(rd_out), 32'(e.res[4:0]));
          chk("pc_tgt", pc_tgt_out, ~e.res);
          chk("b", b_out, e.res ^ 32'h5A5A_5A5A);
          chk("zero", 32'(zero_out), 32'(e.res[0]));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [31:0] res, input logic [4:0] ctl,
                       input logic ordy);
    in_valid  = iv;
    result_in = res;
    pc_tgt_in = ~res;
    b_in      = res ^ 32'h5A5A_5A5A;
    rd_in     = res[4:0];
    zero_in   = res[0];
    ctrl_in   = ctl;
    out_ready = ordy;
  endtask

  task automatic drain_all();
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    for (int i = 0; i < 10 && (sb.size() != 0 || out_valid); i++) tick();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    reset = 1'b1;
    flush = 1'b0;
    perf_clr = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("rst_result", result_out, 32'd0);
    reset = 1'b0;

    // First transfer: one-cycle latency
    drive(1'b1, 32'h0000_00AA, 5'b01000, 1'b1);
    chk("first_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_result", result_out, 32'hAA);
    chk("first_ctrl", 32'(ctrl_out), 32'b01000);
    chk("first_occ", 32'(occupancy), 32'd1);

    // Back-to-back stream at full throughput
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), (i % 2 == 1) ? 5'b01011 : 5'b10110, 1'b1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_result", result_out, 32'(i));
    end
    drain_all();

    // Back-pressure fills the skid buffer
    base = npop;
    drive(1'b1, 32'h10, 5'b00011, 1'b0);
    tick();
    drive(1'b1, 32'h11, 5'b00101, 1'b0);
    tick();
    chk("full_occ", 32'(occupancy), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h12, 5'b11001, 1'b0);
    tick();
    chk("held_occ", 32'(occupancy), 32'd2);
    chk("held_result", result_out, 32'h10);
    drive(1'b1, 32'h12, 5'b11001, 1'b1);
    tick();
    tick();
    drain_all();
    chk("backpressure_count", 32'(npop - base), 32'd3);

    // Flush while full, with a valid input in the same cycle
    drive(1'b1, 32'h20, 5'b01010, 1'b0);
    tick();
    drive(1'b1, 32'h21, 5'b01100, 1'b0);
    tick();
    chk("pre_flush_occ", 32'(occupancy), 32'd2);
    flush = 1'b1;
    drive(1'b1, 32'h99, 5'b11111, 1'b1);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_ctrl", 32'(ctrl_out), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-cycle while full
    drive(1'b1, 32'h30, 5'b01001, 1'b0);
    tick();
    drive(1'b1, 32'h31, 5'b01110, 1'b0);
    tick();
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_occ", 32'(occupancy), 32'd0);
    chk("async_rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

`ifdef EX_MEM_PERF_EN
    perf_clr = 1'b1;
    drive(1'b1, 32'h40, 5'b01000, 1'b0);
    tick();
    perf_clr = 1'b0;
    drive(1'b0, 32'h0, 5'h0, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    tick();
    tick();
    tick();
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
    chk("bubble_cnt", 32'(bubble_cnt), 32'd2);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("stall_clr", 32'(stall_cnt), 32'd0);
    chk("bubble_clr", 32'(bubble_cnt), 32'd0);
`else
    drive(1'b1, 32'h40, 5'b01000, 1'b0);
    tick();
    tick();
    drive(1'b0, 32'h0, 5'h0, 1'b1);
    tick();
    tick();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("stall_cnt_tied", 32'(stall_cnt), 32'd0);
    chk("bubble_cnt_tied", 32'(bubble_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
